// File: rtl/can_tx_arbiter.sv
// can_tx_arbiter: lowest-id arbitration of NUM_MB mailboxes onto one CAN tx.
// Define CANARB_WDOG_EN to add the tx_busy rise watchdog (mb_err).
module can_tx_arbiter #(
  parameter int NUM_MB       = 4,
  parameter int IDX_W        = 3,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   arb_en,
  input  logic [NUM_MB-1:0]      mb_req,
  input  logic [NUM_MB*29-1:0]   mb_id,
  input  logic [NUM_MB*27-1:0]   mb_cmd,
  input  logic [NUM_MB*64-1:0]   mb_data,
  output logic [NUM_MB-1:0]      mb_done,
  output logic [NUM_MB-1:0]      mb_err,
  input  logic                   tx_busy,
  output logic                   tx_startXmit,
  output logic [7:0]             tx_quantaDiv,
  output logic [5:0]             tx_propQuanta,
  output logic [5:0]             tx_seg1Quanta,
  output logic [3:0]             tx_datalen,
  output logic                   tx_format,
  output logic [1:0]             tx_frameType,
  output logic [28:0]            tx_id,
  output logic [63:0]            tx_xmitdata,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   arb_busy
);

  if ((2**IDX_W) < NUM_MB || BUSY_TIMEOUT < 2) begin : g_bad_param
    $error("can_tx_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [28:0]       id_q, id_d;
  logic [26:0]       cmd_q, cmd_d;
  logic [63:0]       data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              gv_q, gv_d;
  logic              start_q, start_d;
  logic              abusy_q, abusy_d;
  logic [NUM_MB-1:0] done_q, done_d;
  logic [NUM_MB-1:0] grant_oh;
  logic              wd_expire;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [28:0]       win_id;
  logic [26:0]       win_cmd;
  logic [63:0]       win_data;

  // Strict less-than keeps the lowest index on equal ids.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_id    = '0;
    win_cmd   = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (mb_req[i] && (!win_found || mb_id[i*29 +: 29] < win_id)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_id    = mb_id[i*29 +: 29];
        win_cmd   = mb_cmd[i*27 +: 27];
        win_data  = mb_data[i*64 +: 64];
      end
    end
  end

  assign grant_oh = NUM_MB'(1) << idx_q;

`ifdef CANARB_WDOG_EN
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_MB-1:0] err_q, err_d;

  // Expiry is decided one cycle early so mb_err lands BUSY_TIMEOUT after START.
  assign wd_expire = (state_q == WAIT_BUSY) && !tx_busy &&
                     (cnt_q == CNT_W'(BUSY_TIMEOUT - 2));

  always_comb begin
    cnt_d = cnt_q;
    err_d = '0;
    if (state_q == START) begin
      cnt_d = '0;
    end else if (state_q == WAIT_BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (wd_expire) begin
      err_d = grant_oh;
    end
  end

  assign mb_err = err_q;
`else
  assign wd_expire = 1'b0;
  assign mb_err    = '0;
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (arb_en && win_found) begin
          state_d = START;
          id_d    = win_id;
          cmd_d   = win_cmd;
          data_d  = win_data;
          idx_d   = win_idx;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (wd_expire) begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    start_d = (state_d == START);
    gv_d    = (state_d != IDLE);
    abusy_d = (state_d != IDLE);
    done_d  = (state_d == DONE) ? grant_oh : '0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      id_q    <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      gv_q    <= 1'b0;
      start_q <= 1'b0;
      abusy_q <= 1'b0;
      done_q  <= '0;
`ifdef CANARB_WDOG_EN
      cnt_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      gv_q    <= gv_d;
      start_q <= start_d;
      abusy_q <= abusy_d;
      done_q  <= done_d;
`ifdef CANARB_WDOG_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign tx_startXmit  = start_q;
  assign tx_quantaDiv  = cmd_q[26:19];
  assign tx_propQuanta = cmd_q[18:13];
  assign tx_seg1Quanta = cmd_q[12:7];
  assign tx_datalen    = cmd_q[6:3];
  assign tx_format     = cmd_q[2];
  assign tx_frameType  = cmd_q[1:0];
  assign tx_id         = id_q;
  assign tx_xmitdata   = data_q;
  assign grant_valid   = gv_q;
  assign grant_idx     = idx_q;
  assign arb_busy      = abusy_q;
  assign mb_done       = done_q;

endmodule
